// File: rtl/display_pkg.sv
// Shared screen geometry and timer FSM encoding for the border display blocks.
package display_pkg;

    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;
    localparam int DIGIT_W    = 16;
    localparam int DIGIT_H    = 16;

    // Timer strip is three glyphs wide, centred on the bottom rows.
    localparam int TIME_LEFT  = VGA_WIDTH / 2 - (3 * DIGIT_W) / 2;
    localparam int TIME_TOP   = VGA_HEIGHT - DIGIT_H;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter that stops at 999; sat flags the saturated value.
module bcd_counter3
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       srst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       sat
);

    assign sat = (d2 == BCD_MAX) && (d1 == BCD_MAX) && (d0 == BCD_MAX);

    always_ff @(posedge clk) begin
        if (!srst_n || clr) begin
            d2 <= 4'd0;
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (inc && !sat) begin
            // Ripple carries resolve combinationally so all digits move together.
            if (d0 == BCD_MAX) begin
                d0 <= 4'd0;
                if (d1 == BCD_MAX) begin
                    d1 <= 4'd0;
                    d2 <= d2 + 4'd1;
                end else begin
                    d1 <= d1 + 4'd1;
                end
            end else begin
                d0 <= d0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_digit_ctrl.sv
// Game timer sequencer: start/pause/over FSM, seconds prescaler, BCD count,
// per-frame snapshot and registered pixel-to-digit lookup for the timer strip.
module time_digit_ctrl
    import display_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic         vga_clk,
    input  logic         sys_rst_n,
    input  logic         game_start,
    input  logic         game_pause,
    input  logic         game_over,
    input  logic [9:0]   pix_x,
    input  logic [9:0]   pix_y,
    output logic [3:0]   time_1s,
    output logic [3:0]   time_10s,
    output logic [3:0]   time_100s,
    output logic [3:0]   number_i,
    output logic [3:0]   number_x,
    output logic [3:0]   number_y,
    output logic         digit_en,
    output logic         time_up,
    output timer_state_t timer_state
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

    localparam logic [10:0] AREA_L  = 11'(TIME_LEFT);
    localparam logic [10:0] AREA_R  = 11'(TIME_LEFT + 3 * DIGIT_W);
    localparam logic [10:0] AREA_T  = 11'(TIME_TOP);
    localparam logic [10:0] AREA_B  = 11'(VGA_HEIGHT);
    localparam logic [10:0] DW_1    = 11'(DIGIT_W);
    localparam logic [10:0] DW_2    = 11'(2 * DIGIT_W);

    // Handshake: game_start/game_over are single-cycle pulses sampled on
    // vga_clk; game_pause is a level. No backpressure exists on any input.
    timer_state_t state, state_nxt;
    logic          start_take;
    logic          run_ok;
    logic          cnt_en;
    logic          cnt_clr;
    logic          pre_clr;
    logic          tick;
    logic          sat;
    logic [PW-1:0] pre;

    assign start_take  = game_start && !game_pause && !game_over;
    assign run_ok      = !game_pause && !game_over && !sat;
    assign tick        = cnt_en && (pre == PRE_LAST);
    assign timer_state = state;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_take) begin
                    state_nxt = RUN;
                end
            end
            RUN, PAUSE: begin
                if (game_over || (state == RUN && sat)) begin
                    state_nxt = DONE;
                end else if (game_pause) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Releasing pause counts in the same cycle, so the prescaler sees no bubble.
    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        pre_clr = 1'b0;
        time_up = 1'b0;
        case (state)
            IDLE, DONE: begin
                pre_clr = 1'b1;
                cnt_clr = start_take;
            end
            RUN: begin
                cnt_en  = run_ok;
                time_up = sat;
            end
            PAUSE: begin
                cnt_en = run_ok;
            end
            default: begin
                pre_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n || pre_clr) begin
            pre <= '0;
        end else if (cnt_en) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    bcd_counter3 u_bcd (
        .clk    (vga_clk),
        .srst_n (sys_rst_n),
        .clr    (cnt_clr),
        .inc    (tick),
        .d2     (time_100s),
        .d1     (time_10s),
        .d0     (time_1s),
        .sat    (sat)
    );

    logic [3:0] snap2, snap1, snap0;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            snap2 <= 4'd0;
            snap1 <= 4'd0;
            snap0 <= 4'd0;
        end else if (pix_x == 10'd0 && pix_y == 10'd0) begin
            snap2 <= time_100s;
            snap1 <= time_10s;
            snap0 <= time_1s;
        end
    end

    logic [10:0] px, py, rel_x;
    logic        in_area;
    logic [3:0]  pix_num, pix_gx, pix_gy;

    // 11-bit compares keep pix_x < L from wrapping into the strip.
    assign px      = {1'b0, pix_x};
    assign py      = {1'b0, pix_y};
    assign rel_x   = px - AREA_L;
    assign in_area = (px >= AREA_L) && (px < AREA_R) && (py >= AREA_T) && (py < AREA_B);

    always_comb begin
        pix_num = 4'd0;
        pix_gx  = 4'd0;
        pix_gy  = 4'd0;
        if (in_area) begin
            pix_gy = 4'(py - AREA_T);
            if (rel_x < DW_1) begin
                pix_num = snap2;
                pix_gx  = 4'(rel_x);
            end else if (rel_x < DW_2) begin
                pix_num = snap1;
                pix_gx  = 4'(rel_x - DW_1);
            end else begin
                pix_num = snap0;
                pix_gx  = 4'(rel_x - DW_2);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            digit_en <= 1'b0;
            number_i <= 4'd0;
            number_x <= 4'd0;
            number_y <= 4'd0;
        end else begin
            digit_en <= in_area;
            number_i <= pix_num;
            number_x <= pix_gx;
            number_y <= pix_gy;
        end
    end

endmodule
